// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with glitch rejection, error flags and data-ready handshake.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit (needs CLKS_PER_BIT >= 6).
module uart_rx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_rdy,
    output logic                 frame_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] T_START = TW'(HALF);
`else
    localparam logic [TW-1:0] T_START = TW'(HALF - 1);
`endif
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [1:0]           sync_q;
    logic                 prev_q;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 rdy_q, rdy_d, fv_q, fv_d, pe_q, pe_d, fe_q, fe_d, ov_q, ov_d;
    logic                 rx_s, sample, tick, done;

    assign rx_s = sync_q[1];
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;
    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign sample = rx_s;
`endif
    assign tick = (timer_q == T_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            hist_q  <= 2'b11;
`endif
            sh_q    <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            fv_q    <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            sync_q  <= {sync_q[0], rx};
            prev_q  <= rx_s;
`ifdef UART_RX_MAJORITY_EN
            hist_q  <= {hist_q[0], rx_s};
`endif
            sh_q    <= sh_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            fv_q    <= fv_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        fv_d    = 1'b0;
        pe_d    = pe_q;
        fe_d    = fe_q;
        ov_d    = ov_q;
        done    = 1'b0;
        if (rd_ack && rdy_q) begin
            rdy_d = 1'b0;
            ov_d  = 1'b0;
        end
        case (state_q)
            IDLE: begin
                timer_d = '0;
                bit_d   = '0;
                ferr_d  = 1'b0;
                // a held-low line keeps prev_q low, so only a real high-to-low edge starts a frame
                if (prev_q && !rx_s) state_d = START;
            end
            START: if (timer_q == T_START) begin
                timer_d = '0;
                state_d = sample ? IDLE : DATA;
            end
            DATA: if (tick) begin
                timer_d = '0;
                sh_d    = {sample, sh_q[DATA_BITS-1:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == B_DATA) begin
                    bit_d   = '0;
                    state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                end
            end
            PARITY: if (tick) begin
                timer_d = '0;
                perr_d  = (^sh_q) ^ sample ^ (PARITY_MODE == 2);
                state_d = STOP;
            end
            STOP: if (tick) begin
                timer_d = '0;
                ferr_d  = ferr_q | ~sample;
                bit_d   = bit_q + 1'b1;
                if (bit_q == B_STOP) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // an ack in the completion cycle consumes the old frame, so no overrun then
        if (done) begin
            data_d = sh_q;
            pe_d   = perr_q;
            fe_d   = ferr_q | ~sample;
            fv_d   = 1'b1;
            rdy_d  = 1'b1;
            if (rdy_q && !rd_ack) ov_d = 1'b1;
        end
    end

    assign data        = data_q;
    assign data_rdy    = rdy_q;
    assign frame_valid = fv_q;
    assign parity_err  = pe_q;
    assign frame_err   = fe_q;
    assign overrun_err = ov_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed self-checking bench for uart_rx_param at default parameters.
module tb_uart_rx_param;
    localparam int CPB  = 10;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] data;
    logic       data_rdy, frame_valid, parity_err, frame_err, overrun_err;
    int         n_cmp = 0;
    int         n_err = 0;
    int         fv_cnt = 0;
    int         fv0;

    uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rd_ack(rd_ack),
        .data(data), .data_rdy(data_rdy), .frame_valid(frame_valid),
        .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_valid) fv_cnt <= fv_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // glitch_bit >= 0 flips rx for one cycle mid-way through that data bit
    task automatic send(input logic [7:0] d, input logic par, input logic stp, input int glitch_bit);
        logic [10:0] f;
        f = {stp, par, d, 1'b0};
        for (int i = 0; i < 11; i++)
            for (int c = 0; c < CPB; c++) begin
                rx = (i == glitch_bit + 1 && c == HALF - 1) ? ~f[i] : f[i];
                @(negedge clk);
            end
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic ack();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_rdy", data_rdy, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_pe", parity_err, 0);
        check("rst_fe", frame_err, 0);
        check("rst_ov", overrun_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        fv0 = fv_cnt;
        send(8'hC1, 1'b1, 1'b1, -1);
        check("c1_fv", fv_cnt - fv0, 1);
        check("c1_data", data, 32'hC1);
        check("c1_pe", parity_err, 0);
        check("c1_fe", frame_err, 0);
        check("c1_rdy", data_rdy, 1);
        ack();
        check("c1_ack_rdy", data_rdy, 0);

        fv0 = fv_cnt;
        send(8'h41, 1'b1, 1'b1, -1);
        check("41_fv", fv_cnt - fv0, 1);
        check("41_data", data, 32'h41);
        check("41_pe", parity_err, 1);
        check("41_fe", frame_err, 0);
        ack();

        fv0 = fv_cnt;
        send(8'h5A, 1'b0, 1'b0, -1);
        check("5a_fv", fv_cnt - fv0, 1);
        check("5a_data", data, 32'h5A);
        check("5a_fe", frame_err, 1);
        check("5a_pe", parity_err, 0);
        ack();
        send(8'h3C, 1'b0, 1'b1, -1);
        check("3c_fv", fv_cnt - fv0, 2);
        check("3c_data", data, 32'h3C);
        check("3c_fe", frame_err, 0);
        check("3c_pe", parity_err, 0);
        ack();

        fv0 = fv_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_fv", fv_cnt - fv0, 0);
        check("glitch_data", data, 32'h3C);
        check("glitch_rdy", data_rdy, 0);

        fv0 = fv_cnt;
        send(8'h11, 1'b0, 1'b1, -1);
        send(8'h22, 1'b0, 1'b1, -1);
        check("ovr_fv", fv_cnt - fv0, 2);
        check("ovr_data", data, 32'h22);
        check("ovr_ov", overrun_err, 1);
        check("ovr_rdy", data_rdy, 1);
        ack();
        check("ovr_ack_rdy", data_rdy, 0);
        check("ovr_ack_ov", overrun_err, 0);

        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        fv0 = fv_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", data, 0);
        check("mid_rst_rdy", data_rdy, 0);
        check("mid_rst_fv", frame_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("mid_rst_nofv", fv_cnt - fv0, 0);
        check("mid_rst_ov", overrun_err, 0);
        send(8'hA5, 1'b0, 1'b1, -1);
        check("a5_fv", fv_cnt - fv0, 1);
        check("a5_data", data, 32'hA5);
        check("a5_pe", parity_err, 0);
        check("a5_fe", frame_err, 0);
        ack();

`ifdef UART_RX_MAJORITY_EN
        fv0 = fv_cnt;
        send(8'hF0, 1'b0, 1'b1, 3);
        check("maj_fv", fv_cnt - fv0, 1);
        check("maj_data", data, 32'hF0);
        check("maj_pe", parity_err, 0);
        ack();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
